instance_allocator: RTL

Hardware instance-handle allocator sitting directly downstream of the type factory stage. Accepts create requests carrying a type ID, issues a unique instance handle from a free list, and returns the handle with the resolved type. Accepts handle releases back into the pool. Provides the object-lifetime bookkeeping that the factory's create path consumes.

---
 rtl/instance_alloc_pkg.sv | 20 ++
 rtl/instance_allocator_handle_free_list.sv | 57 +++++
 rtl/instance_allocator.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/instance_alloc_pkg.sv
// Shared types for the instance-handle allocator.
// Pool size and type width live here so every stage agrees.
package instance_alloc_pkg;

  localparam int TYPE_W   = 4;
  localparam int HANDLE_W = 5;
  localparam int N        = 2**HANDLE_W;

  typedef logic [TYPE_W-1:0]   type_id_t;
  typedef logic [HANDLE_W-1:0] handle_t;
  typedef logic [HANDLE_W:0]   count_t;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam count_t POOL_FULL = count_t'(N);

endpackage

// File: rtl/instance_allocator_handle_free_list.sv
// Circular FIFO of free instance handles.
// Capacity equals the pool size, so it can never legally overflow.
module handle_free_list
  import instance_alloc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [HANDLE_W-1:0] push_data,
  input  logic                pop,
  output logic [HANDLE_W-1:0] pop_data,
  output logic [HANDLE_W:0]   count
);

  handle_t mem [N];
  handle_t head;
  handle_t tail;

  // storage write; contents need no reset, pointers gate validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  // head/tail pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[head];

  // upstream guarantees: no push into a full pool, no pop from empty
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count == POOL_FULL));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/instance_allocator.sv
// Instance-handle allocator: free-list issue, release and ownership.
// Optional INSTANCE_ALLOCATOR_OVERRIDE_EN adds a type override table.
module instance_allocator
  import instance_alloc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TYPE_W-1:0]   req_type,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [HANDLE_W-1:0] rsp_handle,
  output logic [TYPE_W-1:0]   rsp_type,
  input  logic                rel_valid,
  input  logic [HANDLE_W-1:0] rel_handle,
  output logic                rel_err,
  output logic [HANDLE_W:0]   free_count,
  output logic                init_done
`ifdef INSTANCE_ALLOCATOR_OVERRIDE_EN
  ,
  input  logic                ovr_wr,
  input  logic [TYPE_W-1:0]   ovr_from,
  input  logic [TYPE_W-1:0]   ovr_to
`endif
);

  state_t        state_q;
  state_t        state_d;
  handle_t       wr_cnt;
  logic [N-1:0]  owned;
  logic          init_push;
  logic          run;
  logic          accept;
  logic          rel_ok;
  logic          fl_push;
  handle_t       fl_push_data;
  handle_t       fl_pop_data;
  type_id_t      resolved;

  // state register and init write counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      wr_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // next state: seed every handle once, then serve requests
  always_comb begin
    state_d   = state_q;
    init_push = 1'b0;
    unique case (state_q)
      INIT: begin
        init_push = 1'b1;
        if (wr_cnt == handle_t'(N-1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign run       = (state_q == RUN);
  assign init_done = run;
  assign req_ready = run
                   && (free_count != '0)
                   && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rel_ok    = run && rel_valid && owned[rel_handle];

  // init seeding and releases never coincide
  always_comb begin
    fl_push      = 1'b0;
    fl_push_data = '0;
    unique case (1'b1)
      init_push: begin
        fl_push      = 1'b1;
        fl_push_data = wr_cnt;
      end
      rel_ok: begin
        fl_push      = 1'b1;
        fl_push_data = rel_handle;
      end
      default: begin
        fl_push      = 1'b0;
        fl_push_data = '0;
      end
    endcase
  end

  handle_free_list u_free_list (
    .clk       (clk),
    .rst       (rst),
    .push      (fl_push),
    .push_data (fl_push_data),
    .pop       (accept),
    .pop_data  (fl_pop_data),
    .count     (free_count)
  );

  // ownership bits; a popped handle is never owned so no index clash
  always_ff @(posedge clk) begin
    if (rst) begin
      owned <= '0;
    end else begin
      if (accept) begin
        owned[fl_pop_data] <= 1'b1;
      end
      if (rel_ok) begin
        owned[rel_handle] <= 1'b0;
      end
    end
  end

  // one-cycle reject pulse for bad or early releases
  always_ff @(posedge clk) begin
    if (rst) begin
      rel_err <= 1'b0;
    end else begin
      rel_err <= rel_valid && !rel_ok;
    end
  end

  // response register, held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_handle <= '0;
      rsp_type   <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_handle <= fl_pop_data;
      rsp_type   <= resolved;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef INSTANCE_ALLOCATOR_OVERRIDE_EN
  type_id_t ovr_tbl [2**TYPE_W];

  // override table, identity after reset; reads see the old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**TYPE_W; i++) begin
        ovr_tbl[i] <= type_id_t'(i);
      end
    end else if (ovr_wr) begin
      ovr_tbl[ovr_from] <= ovr_to;
    end
  end

  assign resolved = ovr_tbl[req_type];
`else
  assign resolved = req_type;
`endif

endmodule
